// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter merging N_REQ valid/ready senders onto one downstream channel,
// with optional burst lock and a registered output slice for full-throughput hand-off.
module handshake_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int BURST = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         valid_i,
  input  logic [N_REQ*DW-1:0]      data_i,
  output logic [N_REQ-1:0]         ready_o,
  output logic                     valid_o,
  output logic [DW-1:0]            data_o,
  output logic [$clog2(N_REQ)-1:0] src_o,
  input  logic                     ready_i
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(BURST + 1);

  // Index increment modulo N_REQ, so non-power-of-2 requester counts wrap correctly.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
    if (idx == IDW'(N_REQ - 1)) return '0;
    return idx + 1'b1;
  endfunction

  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IDW-1:0]   start);
    logic [IDW-1:0] idx;
    logic [IDW-1:0] pick;
    logic           found;
    idx   = start;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return pick;
  endfunction

  logic           valid_p0;
  logic [DW-1:0]  data_p0;
  logic [IDW-1:0] src_p0;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] owner;
  logic [CW-1:0]  cnt;

  logic           slot_free;
  logic           lock;
  logic [IDW-1:0] sel;
  logic           xfer;
  logic [DW-1:0]  sel_data;

  // Selection and handshake: only the selected requester ever sees ready.
  always_comb begin
    slot_free = ~valid_p0 | ready_i;
    lock      = (cnt != '0) && valid_i[owner];
    sel       = lock ? owner : rr_pick(valid_i, ptr);
    xfer      = slot_free & valid_i[sel];
    sel_data  = data_i[int'(sel)*DW +: DW];
    ready_o      = '0;
    ready_o[sel] = xfer;
  end

  // Output slice plus arbitration state; a held beat stays put until ready_i.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_p0 <= 1'b0;
      data_p0  <= '0;
      src_p0   <= '0;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
    end else begin
      if (xfer) begin
        valid_p0 <= 1'b1;
        data_p0  <= sel_data;
        src_p0   <= sel;
        ptr      <= wrap_inc(sel);
        if (sel == owner && cnt != '0) begin
          cnt <= (int'(cnt) + 1 == BURST) ? '0 : cnt + 1'b1;
        end else begin
          owner <= sel;
          cnt   <= (BURST == 1) ? '0 : CW'(1);
        end
      end else begin
        if (ready_i) valid_p0 <= 1'b0;
        // Owner went idle: drop the lock so arbitration resumes after it.
        if (slot_free && !valid_i[owner]) cnt <= '0;
      end
    end
  end

  assign valid_o = valid_p0;
  assign data_o  = data_p0;
  assign src_o   = src_p0;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Scoreboard bench for handshake_rr_arbiter: one pure round-robin instance and one
// burst-of-3 instance, directed sequences plus a randomized per-source ordering run.
module tb_handshake_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [3:0]  v1, r1o, v3, r3o;
  logic [31:0] d1, d3;
  logic        vo1, vo3, ri1, ri3;
  logic [7:0]  do1, do3;
  logic [1:0]  so1, so3;

  handshake_rr_arbiter #(.N_REQ(4), .DW(8), .BURST(1)) u1 (
    .clk(clk), .reset_n(reset_n), .valid_i(v1), .data_i(d1), .ready_o(r1o),
    .valid_o(vo1), .data_o(do1), .src_o(so1), .ready_i(ri1));

  handshake_rr_arbiter #(.N_REQ(4), .DW(8), .BURST(3)) u3 (
    .clk(clk), .reset_n(reset_n), .valid_i(v3), .data_i(d3), .ready_o(r3o),
    .valid_o(vo3), .data_o(do3), .src_o(so3), .ready_i(ri3));

  int tests = 0;
  int fails = 0;
  logic [9:0] q1[$];
  logic [9:0] q3[$];
  bit rnd = 1'b0;
  int recv[4];
  int sent[4];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the BURST=1 instance: consumes a beat whenever valid_o & ready_i.
  always @(negedge clk) begin
    if (reset_n) begin
      if (vo1 && ri1) begin
        if (rnd) begin
          check("rnd_order", int'(do1), recv[so1] & 255);
          check("rnd_no_dup", int'(recv[so1] < 200), 1);
          recv[so1]++;
        end else if (q1.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL u1_unexpected_beat: got src %0d data %0h, expected none", so1, do1);
        end else begin
          check("u1_beat", int'({so1, do1}), int'(q1.pop_front()));
        end
      end
      if (rnd) check("rnd_ready_onehot", int'($onehot0(r1o)), 1);
    end
  end

  always @(negedge clk) begin
    if (reset_n && vo3 && ri3) begin
      if (q3.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL u3_unexpected_beat: got src %0d data %0h, expected none", so3, do3);
      end else begin
        check("u3_beat", int'({so3, do3}), int'(q3.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] acc;
    bit done;
    reset_n = 1'b0;
    v1 = '0; v3 = '0; d1 = '0; d3 = '0; ri1 = 1'b0; ri3 = 1'b0;
    #12;
    check("rst_valid", int'(vo1), 0);
    check("rst_data", int'(do1), 0);
    check("rst_src", int'(so1), 0);
    check("rst_ready", int'(r1o), 0);
    check("rst_valid_b3", int'(vo3), 0);
    @(negedge clk) reset_n = 1'b1;
    step(1);

    // Pure round-robin, all requesters valid.
    d1 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    v1 = 4'hF;
    ri1 = 1'b1;
    for (int i = 0; i < 8; i++) q1.push_back({2'(i % 4), 8'(8'hA0 + i % 4)});
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("t1_valid_every_cycle", int'(vo1), 1);
    end

    // Back-to-back pop+push, then downstream stall with stable output.
    d1[15:8] = 8'h55;
    v1 = 4'b0010;
    q1.push_back({2'd1, 8'h55});
    step(1);
    ri1 = 1'b0;
    v1 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", int'(vo1), 1);
      check("t3_hold_src", int'(so1), 1);
      check("t3_hold_data", int'(do1), 8'h55);
      check("t3_ready_low", int'(r1o), 0);
      step(1);
    end
    ri1 = 1'b1;
    q1.push_back({2'd2, 8'hA2});
    step(1);

    // Single active requester streams at full rate.
    d1[23:16] = 8'h3C;
    v1 = 4'b0100;
    for (int i = 0; i < 6; i++) q1.push_back({2'd2, 8'h3C});
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("t4_valid", int'(vo1), 1);
      check("t4_src", int'(so1), 2);
    end
    v1 = '0;
    step(2);
    check("t4_drain", q1.size(), 0);

    // Asynchronous reset with a beat held in the output slice.
    d1[7:0] = 8'h77;
    v1 = 4'b0001;
    ri1 = 1'b0;
    step(1);
    v1 = '0;
    check("t6_loaded_valid", int'(vo1), 1);
    check("t6_loaded_data", int'(do1), 8'h77);
    step(2);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_valid", int'(vo1), 0);
    check("t6_async_data", int'(do1), 0);
    check("t6_async_src", int'(so1), 0);
    d1[15:8] = 8'h66;
    v1 = 4'b0110;
    ri1 = 1'b1;
    q1.push_back({2'd1, 8'h66});
    @(negedge clk) reset_n = 1'b1;
    step(1);
    v1 = '0;
    check("t6_first_grant", int'(so1), 1);
    step(2);
    check("t6_drain", q1.size(), 0);

    // BURST=3 rotation.
    d3 = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    v3 = 4'hF;
    ri3 = 1'b1;
    for (int i = 0; i < 15; i++) q3.push_back({2'((i / 3) % 4), 8'(8'hB0 + (i / 3) % 4)});
    step(15);

    // Lock break: owner drops after one beat, next owner gets a full burst.
    v3 = 4'b1000;
    for (int i = 0; i < 3; i++) q3.push_back({2'd3, 8'hB3});
    step(3);
    v3 = 4'b0001;
    q3.push_back({2'd0, 8'hB0});
    step(1);
    v3 = 4'b1110;
    for (int i = 0; i < 3; i++) q3.push_back({2'd1, 8'hB1});
    q3.push_back({2'd2, 8'hB2});
    step(4);
    v3 = '0;
    step(2);
    check("t5_drain", q3.size(), 0);

    // Randomized traffic with per-source incrementing data.
    for (int k = 0; k < 4; k++) begin
      sent[k] = 0;
      recv[k] = 0;
    end
    v1 = '0;
    d1 = '0;
    ri1 = 1'b0;
    rnd = 1'b1;
    done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(negedge clk);
      acc = v1 & r1o;
      step(1);
      for (int k = 0; k < 4; k++) begin
        if (acc[k]) begin
          sent[k]++;
          v1[k] = 1'b0;
        end
        if (!v1[k] && sent[k] < 200) v1[k] = ($urandom_range(0, 3) != 0);
        d1[k*8 +: 8] = 8'(sent[k]);
      end
      ri1 = ($urandom_range(0, 9) < 7);
      done = (recv[0] == 200) && (recv[1] == 200) && (recv[2] == 200) && (recv[3] == 200);
    end
    rnd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("rnd_recv_count", recv[k], 200);
      check("rnd_sent_count", sent[k], 200);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
